sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO that succeeds the fixed 8-bit sync_fifo. It is generic in data width and depth. It adds:
- programmable almost-full/almost-empty flags
- an optional first-word-fall-through (FWFT) read mode
- sticky overflow/underflow error flags
- a synchronous flush

It sits between producer and consumer logic in the same clock domain and is the standard buffer for new datapaths.

---
 rtl/sync_fifo_param.sv | 179 +++++++++++++++++
 tb/tb_sync_fifo_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through read mode, sticky overflow and
// underflow error flags, and a synchronous flush.
//
// Parameters
//   DATA_WIDTH : width of data_in / data_out
//   DEPTH      : number of entries (power of 2, >= 4)
//   AF_LEVEL   : almost_full asserts when fifo_cnt >= AF_LEVEL
//   AE_LEVEL   : almost_empty asserts when fifo_cnt <= AE_LEVEL
//   FWFT       : 0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   flush        : synchronous clear of contents and error flags
//   wr, data_in  : write request and write data
//   rd           : read request
//   data_out     : read data
//   empty, full, almost_empty, almost_full : occupancy flags
//   fifo_cnt     : current occupancy 0..DEPTH
//   overflow     : sticky, a write was rejected
//   underflow    : sticky, a read was rejected
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     fifo_cnt,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE    = CW'(AE_LEVEL);

    // Elaboration-time parameter sanity checks
    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_err_depth
            $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
        end
        if (AF_LEVEL > DEPTH) begin : g_err_af
            $error("sync_fifo_param: AF_LEVEL must not exceed DEPTH");
        end
        if (AE_LEVEL >= AF_LEVEL) begin : g_err_ae
            $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [CW-1:0]         w_cnt_nxt;

    // Flags derive from the registered count, so they follow the causing edge
    assign w_empty = (r_cnt == CNT_ZERO);
    assign w_full  = (r_cnt == CNT_DEPTH);

    // A read is only honoured when data exists; a write into a full FIFO is
    // honoured when a simultaneous read frees the head slot.
    assign w_rd_ok = rd & ~w_empty;
    assign w_wr_ok = wr & (~w_full | w_rd_ok);

    // Next occupancy: simultaneous accepted read and write cancel out
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
            2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Pointer, occupancy and sticky error state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= CNT_ZERO;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= CNT_ZERO;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_cnt <= w_cnt_nxt;
            if (wr && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (rd && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage array; intentionally not cleared by reset or flush
    always_ff @(posedge clk) begin
        if (w_wr_ok && !flush) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry presented combinationally; forced to 0 when empty so
            // the output is never X before the first write.
            always_comb begin
                if (w_empty) begin
                    data_out = '0;
                end else begin
                    data_out = r_mem[r_rd_ptr];
                end
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;

            // Registered read data, held when no read is accepted
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_data_out <= '0;
                end else if (flush) begin
                    r_data_out <= '0;
                end else if (w_rd_ok) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_cnt <= CNT_AE);
    assign almost_full  = (r_cnt >= CNT_AF);
    assign fifo_cnt     = r_cnt;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Drives a registered-read and a FWFT instance of sync_fifo_param with the
// same stimulus and compares both against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;

    logic [DW-1:0] dout_a, dout_b;
    logic          empty_a, full_a, ae_a, af_a, ovf_a, udf_a;
    logic          empty_b, full_b, ae_b, af_b, ovf_b, udf_b;
    logic [CW-1:0] cnt_a, cnt_b;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int            q[$];
    bit            m_ovf;
    bit            m_udf;
    logic [DW-1:0] m_dout;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL),
                      .AE_LEVEL(AEL), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr(wr), .data_in(din), .rd(rd),
        .data_out(dout_a), .empty(empty_a), .full(full_a),
        .almost_empty(ae_a), .almost_full(af_a), .fifo_cnt(cnt_a),
        .overflow(ovf_a), .underflow(udf_a)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL),
                      .AE_LEVEL(AEL), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr(wr), .data_in(din), .rd(rd),
        .data_out(dout_b), .empty(empty_b), .full(full_b),
        .almost_empty(ae_b), .almost_full(af_b), .fifo_cnt(cnt_b),
        .overflow(ovf_b), .underflow(udf_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;
    endtask

    task automatic check_all();
        int n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n > 0) ? DW'(q[0]) : '0;
        check_eq("cnt_a",   32'(cnt_a),   32'(n));
        check_eq("cnt_b",   32'(cnt_b),   32'(n));
        check_eq("empty_a", 32'(empty_a), 32'(n == 0));
        check_eq("empty_b", 32'(empty_b), 32'(n == 0));
        check_eq("full_a",  32'(full_a),  32'(n == DEPTH));
        check_eq("full_b",  32'(full_b),  32'(n == DEPTH));
        check_eq("ae_a",    32'(ae_a),    32'(n <= AEL));
        check_eq("ae_b",    32'(ae_b),    32'(n <= AEL));
        check_eq("af_a",    32'(af_a),    32'(n >= AFL));
        check_eq("af_b",    32'(af_b),    32'(n >= AFL));
        check_eq("ovf_a",   32'(ovf_a),   32'(m_ovf));
        check_eq("ovf_b",   32'(ovf_b),   32'(m_ovf));
        check_eq("udf_a",   32'(udf_a),   32'(m_udf));
        check_eq("udf_b",   32'(udf_b),   32'(m_udf));
        check_eq("dout_a",  32'(dout_a),  32'(m_dout));
        check_eq("dout_b",  32'(dout_b),  32'(head));
    endtask

    // One clock: apply inputs, advance model on the edge, check after it
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r,
                         input bit f);
        bit rd_ok, wr_ok;
        wr    = w;
        din   = d;
        rd    = r;
        flush = f;
        @(posedge clk);
        if (f) begin
            model_reset();
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_dout = DW'(q.pop_front());
            if (wr_ok) q.push_back(int'(d));
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && !rd_ok) m_udf = 1'b1;
        end
        #1;
        check_all();
        wr    = 1'b0;
        rd    = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // 1: fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 6) check_eq("t1_af_at6", 32'(af_a), 32'd1);
        end
        check_eq("t1_full", 32'(full_a), 32'd1);
        cycle(1'b1, 8'd99, 1'b0, 1'b0);
        check_eq("t1_ovf", 32'(ovf_a), 32'd1);
        check_eq("t1_cnt8", 32'(cnt_a), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 8'd0, 1'b1, 1'b0);
            check_eq("t1_rd", 32'(dout_a), 32'(i));
        end

        // 2: simultaneous write and read while full
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(10 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'd50, 1'b1, 1'b0);
        check_eq("t2_dout", 32'(dout_a), 32'd11);
        check_eq("t2_cnt",  32'(cnt_a),  32'd8);
        check_eq("t2_ovf",  32'(ovf_a),  32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("t2_last", 32'(dout_a), 32'd50);

        // 3: simultaneous write and read while empty
        cycle(1'b1, 8'd7, 1'b1, 1'b0);
        check_eq("t3_udf", 32'(udf_a), 32'd1);
        check_eq("t3_cnt", 32'(cnt_a), 32'd1);
        cycle(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("t3_rd",    32'(dout_a),  32'd7);
        check_eq("t3_empty", 32'(empty_a), 32'd1);

        // 4: first-word-fall-through behaviour
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        cycle(1'b1, 8'd10, 1'b0, 1'b0);
        check_eq("t4_head10", 32'(dout_b), 32'd10);
        cycle(1'b1, 8'd20, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("t4_head20", 32'(dout_b), 32'd20);
        cycle(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("t4_empty", 32'(empty_b), 32'd1);
        check_eq("t4_zero",  32'(dout_b),  32'd0);

        // 5: flush with content, flags cleared
        cycle(1'b1, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(30 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'd77, 1'b1, 1'b1);
        check_eq("t5_cnt", 32'(cnt_a), 32'd0);
        check_eq("t5_udf", 32'(udf_a), 32'd0);
        cycle(1'b1, 8'd3, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("t5_rd", 32'(dout_a), 32'd3);

        // 6: asynchronous reset mid-burst, then traffic across the wrap
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(60 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check_eq("t6_cnt_rst", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, DW'(100 + i), 1'b0, 1'b0);
            cycle(1'b0, 8'd0, 1'b1, 1'b0);
            check_eq("t6_wrap", 32'(dout_a), 32'(100 + i));
        end

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 55), DW'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
